// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: self-test sequencer for the 2-input logic-gate unit.
// Drives the four (a,b) vectors for LOOPS passes, checks y against a golden
// table after SETTLE_CYCLES of settling, and reports done/pass/err_count.
// Define GATE_TEST_FAULT_LOG_EN to add a first-mismatch log (fail_valid/vec/mask).
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [6:0]       y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       vec_idx
`ifdef GATE_TEST_FAULT_LOG_EN
    ,
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask
`endif
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
    localparam logic [15:0] LAST_SETTLE = 16'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [15:0] LAST_LOOP   = 16'(LOOPS - 1);
    state_t           state;
    logic [15:0]      settle_cnt;
    logic [15:0]      loop_cnt;
    logic [6:0]       golden;
    logic             mismatch;
    logic [1:0]       vec_nxt;
    logic [ERR_W-1:0] err_next;
    // golden response of the current vector and the saturating error count after this check
    always_comb begin
        golden   = vec_idx == 2'd0 ? 7'h59 : vec_idx == 2'd1 ? 7'h2D : vec_idx == 2'd2 ? 7'h2C : 7'h46;
        mismatch = y_in != golden;
        vec_nxt  = vec_idx + 2'd1;
        err_next = (mismatch && err_count != '1) ? err_count + ERR_W'(1) : err_count;
    end
    // sequencer FSM; every output is a register so y_in never reaches an output combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_idx    <= 2'd0;
`ifdef GATE_TEST_FAULT_LOG_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            fail_mask  <= 7'd0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= DRIVE;
                    vec_idx   <= 2'd0;
                    loop_cnt  <= '0;
                    a_out     <= 1'b0;
                    b_out     <= 1'b0;
                    busy      <= 1'b1;
                    err_count <= '0;
                    pass      <= 1'b0;
`ifdef GATE_TEST_FAULT_LOG_EN
                    fail_valid <= 1'b0;
                    fail_vec   <= 2'd0;
                    fail_mask  <= 7'd0;
`endif
                end
                DRIVE: begin
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 16'd1;
                    if (settle_cnt == LAST_SETTLE) state <= CHECK;
                end
                CHECK: begin
                    err_count <= err_next;
`ifdef GATE_TEST_FAULT_LOG_EN
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec_idx;
                        fail_mask  <= y_in ^ golden;
                    end
`endif
                    if (vec_idx != 2'd3) begin
                        vec_idx <= vec_nxt;
                        a_out   <= vec_nxt[1];
                        b_out   <= vec_nxt[0];
                        state   <= DRIVE;
                    end else if (loop_cnt != LAST_LOOP) begin
                        vec_idx  <= 2'd0;
                        loop_cnt <= loop_cnt + 16'd1;
                        a_out    <= 1'b0;
                        b_out    <= 1'b0;
                        state    <= DRIVE;
                    end else begin
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_next == '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: scoreboard bench for gate_test_sequencer in three configurations.
module tb_gate_test_sequencer;
    typedef struct {int err; logic pass;} res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_def = 1'b0, start_sat = 1'b0, start_fast = 1'b0;
    logic [6:0] stuck = 7'd0;
    logic a_def, b_def, busy_def, done_def, pass_def;
    logic [7:0] err_def;
    logic [1:0] vec_def;
    logic a_sat, b_sat, busy_sat, done_sat, pass_sat;
    logic [1:0] err_sat;
    logic [1:0] vec_sat;
    logic a_fast, b_fast, busy_fast, done_fast, pass_fast;
    logic [7:0] err_fast;
    logic [1:0] vec_fast;
    logic [6:0] y_def, y_fast;
    logic [6:0] gold [4] = '{7'h59, 7'h2D, 7'h2C, 7'h46};
`ifdef GATE_TEST_FAULT_LOG_EN
    logic fv_def, fv_sat, fv_fast;
    logic [1:0] fvec_def, fvec_sat, fvec_fast;
    logic [6:0] fm_def, fm_sat, fm_fast;
`endif
    res_t q_def[$], q_sat[$], q_fast[$];
    res_t r;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] gate(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    endfunction

    // expected run result from the bench's own gate model, fault and counter width
    function automatic res_t predict(input int loops, input logic [6:0] mask, input bit tie0, input int err_w);
        res_t e;
        int sat;
        logic [6:0] y;
        e.err = 0;
        sat = (1 << err_w) - 1;
        for (int l = 0; l < loops; l++)
            for (int v = 0; v < 4; v++) begin
                y = tie0 ? 7'd0 : (gate(v[1], v[0]) & ~mask);
                if (y != gold[v]) e.err++;
            end
        e.pass = e.err == 0;
        if (e.err > sat) e.err = sat;
        return e;
    endfunction

    assign y_def  = gate(a_def, b_def) & ~stuck;
    assign y_fast = gate(a_fast, b_fast);

    gate_test_sequencer u_def (
        .clk(clk), .rst(rst), .start(start_def), .a_out(a_def), .b_out(b_def), .y_in(y_def),
        .busy(busy_def), .done(done_def), .pass(pass_def), .err_count(err_def), .vec_idx(vec_def)
`ifdef GATE_TEST_FAULT_LOG_EN
        , .fail_valid(fv_def), .fail_vec(fvec_def), .fail_mask(fm_def)
`endif
    );
    gate_test_sequencer #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_sat), .a_out(a_sat), .b_out(b_sat), .y_in(7'd0),
        .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_count(err_sat), .vec_idx(vec_sat)
`ifdef GATE_TEST_FAULT_LOG_EN
        , .fail_valid(fv_sat), .fail_vec(fvec_sat), .fail_mask(fm_sat)
`endif
    );
    gate_test_sequencer #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(8)) u_fast (
        .clk(clk), .rst(rst), .start(start_fast), .a_out(a_fast), .b_out(b_fast), .y_in(y_fast),
        .busy(busy_fast), .done(done_fast), .pass(pass_fast), .err_count(err_fast), .vec_idx(vec_fast)
`ifdef GATE_TEST_FAULT_LOG_EN
        , .fail_valid(fv_fast), .fail_vec(fvec_fast), .fail_mask(fm_fast)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({a_def, b_def, busy_def, done_def, pass_def, err_def, vec_def} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_def: got %b want 0", {a_def, b_def, busy_def, done_def, pass_def, err_def, vec_def});
        end
        n_vec++;
        if ({busy_sat, done_sat, err_sat, busy_fast, done_fast, err_fast} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_cfg: got %b want 0", {busy_sat, done_sat, err_sat, busy_fast, done_fast, err_fast});
        end
`ifdef GATE_TEST_FAULT_LOG_EN
        n_vec++;
        if ({fv_def, fvec_def, fm_def} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_log: got %b want 0", {fv_def, fvec_def, fm_def});
        end
`endif
        rst = 1'b0;
    endtask

    // one default run with the current stuck mask; start at cycle 0, done expected at 17
    task automatic run_default(input string tag);
        int v;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 16) begin
                v = (c - 1) / 4;
                n_vec++;
                if ({busy_def, a_def, b_def, vec_def} !== {1'b1, 2'(v), 2'(v)}) begin
                    n_bad++;
                    $display("FAIL %s_drive c=%0d: busy/a/b/idx=%b want %b", tag, c,
                             {busy_def, a_def, b_def, vec_def}, {1'b1, 2'(v), 2'(v)});
                end
            end
            n_vec++;
            if (done_def !== (c == 17)) begin
                n_bad++;
                $display("FAIL %s_done c=%0d: got %b want %b", tag, c, done_def, c == 17);
            end
            if (c == 17) begin
                n_vec++;
                if (q_def.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_sb: done with empty scoreboard", tag);
                end else begin
                    r = q_def.pop_front();
                    if (err_def !== 8'(r.err) || pass_def !== r.pass || busy_def !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s_result: err=%0d pass=%b busy=%b want err=%0d pass=%b busy=0",
                                 tag, err_def, pass_def, busy_def, r.err, r.pass);
                    end
                end
            end
            start_def = (c == 0);
            if (c == 0) q_def.push_back(predict(1, stuck, 0, 8));
        end
        start_def = 1'b0;
    endtask

    task automatic test_ideal();
        stuck = 7'd0;
        run_default("ideal");
    endtask

    task automatic test_stuck();
        stuck = 7'h20;
        run_default("stuck");
        n_vec++;
        if (err_def !== 8'd2 || pass_def !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_hold: err=%0d pass=%b want err=2 pass=0", err_def, pass_def);
        end
`ifdef GATE_TEST_FAULT_LOG_EN
        n_vec++;
        if ({fv_def, fvec_def, fm_def} !== {1'b1, 2'd1, 7'h20}) begin
            n_bad++;
            $display("FAIL stuck_log: valid=%b vec=%0d mask=%h want 1/1/20", fv_def, fvec_def, fm_def);
        end
`endif
    endtask

    task automatic test_ignore_start();
        stuck = 7'h20;
        for (int c = 0; c <= 38; c++) begin
            @(negedge clk);
            n_vec++;
            if (done_def !== (c == 17 || c == 37)) begin
                n_bad++;
                $display("FAIL ign_done c=%0d: got %b want %b", c, done_def, c == 17 || c == 37);
            end
            if (c == 17 || c == 37) begin
                n_vec++;
                if (q_def.size() == 0) begin
                    n_bad++;
                    $display("FAIL ign_sb c=%0d: done with empty scoreboard", c);
                end else begin
                    r = q_def.pop_front();
                    if (err_def !== 8'(r.err) || pass_def !== r.pass) begin
                        n_bad++;
                        $display("FAIL ign_result c=%0d: err=%0d pass=%b want err=%0d pass=%b",
                                 c, err_def, pass_def, r.err, r.pass);
                    end
                end
            end
            if (c == 18 || c == 19) begin
                n_vec++;
                if (busy_def !== 1'b0 || err_def !== 8'd2) begin
                    n_bad++;
                    $display("FAIL ign_idle c=%0d: busy=%b err=%0d want busy=0 err=2", c, busy_def, err_def);
                end
            end
            if (c == 21) begin
                n_vec++;
                if (busy_def !== 1'b1 || err_def !== 8'd0 || pass_def !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ign_clear: busy=%b err=%0d pass=%b want 1/0/0", busy_def, err_def, pass_def);
                end
            end
            if (c == 20) stuck = 7'd0;
            start_def = (c == 0 || c == 5 || c == 17 || c == 20);
            if (c == 0) q_def.push_back(predict(1, 7'h20, 0, 8));
            if (c == 20) q_def.push_back(predict(1, 7'd0, 0, 8));
        end
        start_def = 1'b0;
    endtask

    task automatic test_reset_mid();
        stuck = 7'd0;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            n_vec++;
            if (done_def !== (c == 29)) begin
                n_bad++;
                $display("FAIL rmid_done c=%0d: got %b want %b", c, done_def, c == 29);
            end
            if (c == 9 || c == 10) begin
                n_vec++;
                if ({a_def, b_def, busy_def, pass_def, err_def, vec_def} !== 14'd0) begin
                    n_bad++;
                    $display("FAIL rmid_state c=%0d: got %b want 0", c, {a_def, b_def, busy_def, pass_def, err_def, vec_def});
                end
            end
            if (c == 13) begin
                n_vec++;
                if (busy_def !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rmid_restart: busy=%b want 1", busy_def);
                end
            end
            if (c == 29) begin
                n_vec++;
                if (q_def.size() == 0) begin
                    n_bad++;
                    $display("FAIL rmid_sb: done with empty scoreboard");
                end else begin
                    r = q_def.pop_front();
                    if (err_def !== 8'(r.err) || pass_def !== r.pass) begin
                        n_bad++;
                        $display("FAIL rmid_result: err=%0d pass=%b want err=%0d pass=%b", err_def, pass_def, r.err, r.pass);
                    end
                end
            end
            rst = (c == 8);
            start_def = (c == 0 || c == 8 || c == 12);
            if (c == 12) q_def.push_back(predict(1, 7'd0, 0, 8));
        end
        start_def = 1'b0;
    endtask

    task automatic test_saturate();
        for (int c = 0; c <= 34; c++) begin
            @(negedge clk);
            n_vec++;
            if (done_sat !== (c == 33)) begin
                n_bad++;
                $display("FAIL sat_done c=%0d: got %b want %b", c, done_sat, c == 33);
            end
            if (c == 33) begin
                n_vec++;
                if (q_sat.size() == 0) begin
                    n_bad++;
                    $display("FAIL sat_sb: done with empty scoreboard");
                end else begin
                    r = q_sat.pop_front();
                    if (err_sat !== 2'(r.err) || pass_sat !== r.pass) begin
                        n_bad++;
                        $display("FAIL sat_result: err=%0d pass=%b want err=%0d pass=%b", err_sat, pass_sat, r.err, r.pass);
                    end
                end
            end
            if (c == 17) begin
                n_vec++;
                if (busy_sat !== 1'b1 || {a_sat, b_sat} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL sat_loop2: busy=%b ab=%b want busy=1 ab=00", busy_sat, {a_sat, b_sat});
                end
            end
            start_sat = (c == 0);
            if (c == 0) q_sat.push_back(predict(2, 7'd0, 1, 2));
        end
        start_sat = 1'b0;
    endtask

    task automatic test_fast();
        int v;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                v = (c - 1) / 2;
                n_vec++;
                if ({busy_fast, a_fast, b_fast} !== {1'b1, 2'(v)}) begin
                    n_bad++;
                    $display("FAIL fast_drive c=%0d: busy/a/b=%b want %b", c, {busy_fast, a_fast, b_fast}, {1'b1, 2'(v)});
                end
            end
            n_vec++;
            if (done_fast !== (c == 9)) begin
                n_bad++;
                $display("FAIL fast_done c=%0d: got %b want %b", c, done_fast, c == 9);
            end
            if (c == 9) begin
                n_vec++;
                if (q_fast.size() == 0) begin
                    n_bad++;
                    $display("FAIL fast_sb: done with empty scoreboard");
                end else begin
                    r = q_fast.pop_front();
                    if (err_fast !== 8'(r.err) || pass_fast !== r.pass) begin
                        n_bad++;
                        $display("FAIL fast_result: err=%0d pass=%b want err=%0d pass=%b", err_fast, pass_fast, r.err, r.pass);
                    end
                end
            end
            start_fast = (c == 0);
            if (c == 0) q_fast.push_back(predict(1, 7'd0, 0, 8));
        end
        start_fast = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck();
        test_ignore_start();
        test_reset_mid();
        test_saturate();
        test_fast();
        n_vec++;
        if (q_def.size() + q_sat.size() + q_fast.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d results never produced, want 0", q_def.size() + q_sat.size() + q_fast.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-test sequencer for the 2-input logic-gate unit (outputs y[6:0] = NOT a, AND, OR, NAND, NOR, XOR, XNOR). On a start pulse it drives all four (a,b) combinations into the unit for a configurable number of passes and waits a settle interval per vector. It then compares y against a built-in golden table, counts mismatching vectors, and reports done/pass. It sits beside the gate unit and owns that unit's a/b inputs whenever it is busy.

## Interface
- SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling y (0 allowed)
- LOOPS, 1, full passes over the 4 vectors (>=1)
- ERR_W, 8, width of the mismatch counter
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- a_out  out  1  drives gate-unit input a
- b_out  out  1  drives gate-unit input b
- y_in  in  7  gate-unit outputs y[6:0]
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run; high when err_count==0
- err_count  out  ERR_W  number of mismatching vector checks, saturating
- vec_idx  out  2  index of the vector currently applied

## Operation
- Vector i in 0..3 maps to a_out=i[1] and b_out=i[0].
- Golden y per vector: 0 -> 7'h59, 1 -> 7'h2D, 2 -> 7'h2C, 3 -> 7'h46.
- States:
  - IDLE: a_out=b_out=0, busy=0. start -> DRIVE with vec_idx=0 and loop=0; clear err_count, pass, and fault log.
  - DRIVE (1 cycle): a_out/b_out = vector. Go to SETTLE, or to CHECK when SETTLE_CYCLES=0.
  - SETTLE (SETTLE_CYCLES cycles): hold the vector.
  - CHECK (1 cycle): compare y_in with golden. On mismatch, err_count += 1, saturating at 2^ERR_W-1.
    - If vec_idx<3: vec_idx+1 -> DRIVE.
    - Else if loop<LOOPS-1: vec_idx=0, loop+1 -> DRIVE.
    - Else -> DONE.
  - DONE (1 cycle): done=1, busy=0, pass <= (err_count==0 including this run's last check) -> IDLE.
- start outside IDLE, including in DONE, is ignored; no queuing.
- err_count and pass hold their values until the next accepted start.
- Counting is per vector check, not per bit.

## Timing
- Reset values: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, state IDLE. With FAULT_LOG_EN also fail_valid=0, fail_vec=0, fail_mask=0.
- start sampled at edge 0 -> busy=1 and the first vector on a_out/b_out from cycle 1.
- Each vector occupies SETTLE_CYCLES+2 cycles; y_in is sampled in the CHECK cycle.
- done is high in cycle 1 + 4*LOOPS*(SETTLE_CYCLES+2); with the defaults that is cycle 17.
- rst mid-run: next cycle is the reset state, and the partial result is discarded.
- A start in the same cycle as rst is ignored.
- All outputs are registered; there are no combinational paths from y_in to outputs.

## Configuration
- GATE_TEST_FAULT_LOG_EN defined: adds three outputs that capture the first mismatch of a run:
  - fail_valid  out  1
  - fail_vec  out  2
  - fail_mask  out  7, equal to y_in XOR golden
- Once fail_valid is set, later mismatches do not overwrite the log; it is cleared on an accepted start.
- Not defined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Ideal gate model, defaults, start at cycle 0 -> a/b sequence 00,01,10,11 each held 4 cycles; done at cycle 17; pass=1; err_count=0.
- y_in[5] stuck at 0 -> vectors 1 and 2 fail; err_count=2; pass=0; with FAULT_LOG_EN, fail_vec=1 and fail_mask=7'h20.
- start pulses at cycles 5 and 17 (during busy and during DONE) -> ignored, single done at 17. A new start at 20 clears err_count and pass.
- rst asserted at cycle 8 -> next cycle shows all outputs at reset values. A start at 12 then runs a full sequence with done at cycle 29.
- ERR_W=2, LOOPS=2, y_in tied 0 -> 8 mismatches; err_count saturates at 3; done at cycle 33; pass=0.
- SETTLE_CYCLES=0 -> 2 cycles per vector; done at cycle 9.
